ins_queue_parser: RTL
=====================

Name: ins_queue_parser

Overview:
Decode-stage front end that generalises the combinational instruction field parser into a buffered, handshaked stage. A parametrised FIFO of {inst, pc4} pairs sits between fetch and decode, and a registered output stage presents the parsed fields of the head instruction. Sign-extended branch offsets and a precomputed branch target are selectable. Flush and stall integrate with the pipeline hazard logic.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
SIGN_EXT_BOFF, 1, 1 = boff sign-extended from imm; 0 = zero-extended (legacy behaviour)
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  fetch offers an instruction
in_ready  out  1  FIFO can accept; equals !full
in_inst  in  32  fetched instruction word
in_pc4  in  32  PC+4 of the fetched instruction
flush  in  1  discard all buffered and output instructions
out_ready  in  1  decode consumes output; 0 = stall
out_valid  out  1  output fields hold a valid instruction
op  out  6  inst[31:26]
func  out  6  inst[5:0]
rs, rt, rd, sa  out  5 each  inst[25:21], [20:16], [15:11], [10:6]
imm  out  16  inst[15:0]
sa_imm  out  1  op==6'b000000
dpc4  out  32  registered pc4 of the output instruction
jpc  out  32  {pc4[31:28], inst[25:0], 2'b00}
boff  out  32  {{14{imm[15]}},imm,2'b00} if SIGN_EXT_BOFF else {14'b0,imm,2'b00}
btarget  out  32  pc4 + boff, mod 2^32
count  out  CNT_W  FIFO occupancy, excluding the output register

Behaviour:
- Reset (rst=1 at edge): FIFO pointers = 0, count = 0, out_valid = 0, all field/address outputs = 0. in_ready = 1 after reset. rst overrides every other input.
- Push: occurs when in_valid && in_ready && !flush. Writes {in_inst, in_pc4} at the write pointer. Pointers wrap modulo DEPTH.
- Full: count==DEPTH forces in_ready=0. There is no push on the same cycle as a pop from full; no pass-through.
- Load: when (!out_valid || out_ready) && count!=0 && !flush, the head entry is popped. All outputs are computed from the head and registered, and out_valid is set to 1.
- Drain: when out_valid && out_ready && count==0, out_valid goes to 0 and the fields hold their last values.
- Stall: when out_valid && !out_ready, all outputs hold and no pop occurs. Pushes continue until the FIFO is full.
- Latency: a push at edge N is visible on the outputs after edge N+1 at the earliest. There is no bypass from in_* to the outputs.
- Simultaneous push and load: both take effect, and count is unchanged.
- flush=1 at an edge empties the FIFO (pointers and count = 0) and sets out_valid=0. The same-cycle push and load are suppressed. Field outputs hold their values. flush takes priority over out_ready and in_valid.
- Reset asserted mid-stream: all contents are lost, identical to the power-on state.
- Arithmetic: btarget is a 32-bit add that wraps, with no overflow flag. All fields derive from the same registered instruction; there is never a mix of old and new fields.
- count is exact at all times; 0 <= count <= DEPTH.

Test Plan:
- Reset, then idle: out_valid=0, count=0, in_ready=1, jpc=btarget=0.
- R-type decode: push 0x00221820 with pc4=0x00400004, out_ready=1. Out_valid rises 2 edges later with op=0, rs=1, rt=2, rd=3, sa=0, func=0x20, sa_imm=1, dpc4=0x00400004.
- Branch offset: push 0x1000FFFF with pc4=0x00400004. With SIGN_EXT_BOFF=1: boff=0xFFFFFFFC, btarget=0x00400000, sa_imm=0. With SIGN_EXT_BOFF=0: boff=0x0003FFFC, btarget=0x00440000.
- Jump: push 0x08100000 with pc4=0x00400010. Expect op=0x02, jpc=0x00400000.
- Backpressure: hold out_ready=0 and push DEPTH+2 instructions (DEPTH=4). The first is in the output register; count=4, in_ready=0 and the 6th is refused. Outputs stay stable while stalled. Releasing out_ready delivers all 5 in order with no duplicates.
- Flush: with count=3 and out_valid=1, assert flush together with in_valid. Next cycle out_valid=0, count=0 and the in_valid word is dropped. A subsequent push is delivered normally.

Source files
------------

// File: rtl/ins_queue_parser.sv
// ---------------------------------------------------------------------------
// ins_queue_parser
//   Decode-stage front end. A DEPTH-entry FIFO of {inst, pc4} pairs decouples
//   fetch from decode. A registered output stage presents the parsed fields of
//   the head instruction, with a precomputed jump target, branch offset and
//   branch target. Flush empties the stage; out_ready=0 stalls it.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    fetch handshake (in_ready = FIFO not full)
//   in_inst, in_pc4      fetched instruction word and its PC+4
//   flush                discard every buffered and presented instruction
//   out_ready            decode consumes the presented instruction
//   out_valid            output fields hold a valid instruction
//   op..imm, sa_imm      instruction fields of the presented instruction
//   dpc4, jpc, boff,     PC+4, jump target, branch offset and branch target
//   btarget                of the presented instruction
//   count                FIFO occupancy, excluding the output register
// ---------------------------------------------------------------------------
module ins_queue_parser #(
  parameter int DEPTH         = 4,
  parameter bit SIGN_EXT_BOFF = 1'b1,
  parameter int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [31:0]       in_pc4,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        sa,
  output logic [15:0]       imm,
  output logic              sa_imm,
  output logic [31:0]       dpc4,
  output logic [31:0]       jpc,
  output logic [31:0]       boff,
  output logic [31:0]       btarget,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Branch offset: word offset scaled to bytes, sign- or zero-extended.
  function automatic logic [31:0] f_boff(input logic [15:0] imm16);
    logic signed [31:0] s_ext;
    s_ext = {{14{imm16[15]}}, imm16, 2'b00};
    if (SIGN_EXT_BOFF)
      return s_ext;
    else
      return {14'b0, imm16, 2'b00};
  endfunction

  // Jump target: region bits of PC+4 with the 26-bit word index.
  function automatic logic [31:0] f_jpc(input logic [31:0] pc4, input logic [31:0] inst);
    return {pc4[31:28], inst[25:0], 2'b00};
  endfunction

  logic [31:0]      r_inst_mem [DEPTH];
  logic [31:0]      r_pc4_mem  [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             r_out_valid;
  logic [31:0]      r_inst;
  logic [31:0]      r_pc4;
  logic [31:0]      r_jpc;
  logic [31:0]      r_boff;
  logic [31:0]      r_btarget;
  logic             r_sa_imm;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_load;
  logic [31:0]      w_head_inst;
  logic [31:0]      w_head_pc4;
  logic [31:0]      w_head_boff;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign in_ready    = !w_full;
  // in_ready is low when full, so a pop from full never admits a push that cycle.
  assign w_push      = in_valid && !w_full && !flush;
  assign w_load      = (!r_out_valid || out_ready) && !w_empty && !flush;
  assign w_head_inst = r_inst_mem[r_rptr];
  assign w_head_pc4  = r_pc4_mem[r_rptr];
  assign w_head_boff = f_boff(w_head_inst[15:0]);

  // FIFO storage: data only, contents are meaningless once pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wptr] <= in_inst;
      r_pc4_mem[r_wptr]  <= in_pc4;
    end
  end

  // FIFO control and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_inst      <= '0;
      r_pc4       <= '0;
      r_jpc       <= '0;
      r_boff      <= '0;
      r_btarget   <= '0;
      r_sa_imm    <= 1'b0;
    end else if (flush) begin
      // Field outputs deliberately hold; only validity and occupancy clear.
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_load)
        r_rptr <= r_rptr + 1'b1;

      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_inst      <= w_head_inst;
        r_pc4       <= w_head_pc4;
        r_jpc       <= f_jpc(w_head_pc4, w_head_inst);
        r_boff      <= w_head_boff;
        r_btarget   <= w_head_pc4 + w_head_boff;
        r_sa_imm    <= (w_head_inst[31:26] == 6'b000000);
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // All fields are slices of one registered word, so they always change together.
  assign out_valid = r_out_valid;
  assign op        = r_inst[31:26];
  assign rs        = r_inst[25:21];
  assign rt        = r_inst[20:16];
  assign rd        = r_inst[15:11];
  assign sa        = r_inst[10:6];
  assign func      = r_inst[5:0];
  assign imm       = r_inst[15:0];
  assign sa_imm    = r_sa_imm;
  assign dpc4      = r_pc4;
  assign jpc       = r_jpc;
  assign boff      = r_boff;
  assign btarget   = r_btarget;
  assign count     = r_count;

endmodule
